// File: rtl/mem_byte_access_if.sv
// Request, data-memory and writeback-response signals of the MEM-stage access controller.
interface mem_byte_access_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [4:0]        resp_rd;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ack,
    input  resp_valid, resp_data, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ack,
    output resp_valid, resp_data, resp_rd, resp_err
  );
endinterface

// File: rtl/mem_byte_access.sv
// MEM-stage load/store controller: word-addressed req/ack data memory, big-endian byte
// extraction for LB/LBU and read-modify-write for SB, one response per transaction.
module mem_byte_access #(
  parameter int unsigned ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_byte_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_SW  = 3'd3,
    OP_SB  = 3'd4
  } op_t;

  state_t     state, state_next;
  logic [2:0] op_q;
  logic [1:0] lane_q;
  logic [7:0] wbyte_q;
  logic       accept;
  logic       bad_req;

  // pos = {mode, lane}: mode 1x sign-extended extract, 00 zero-extended extract,
  // 01 replace the lane with val. Lane 0 is the most significant byte.
  function automatic logic [31:0] byte_op(input logic [31:0] word,
                                          input logic [3:0]  pos,
                                          input logic [7:0]  val);
    logic [7:0]  b;
    logic [31:0] r;
    r = word;
    case (pos[1:0])
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    if (pos[3]) begin
      r = {{24{b[7]}}, b};
    end else if (!pos[2]) begin
      r = {24'd0, b};
    end else begin
      case (pos[1:0])
        2'd0:    r[31:24] = val;
        2'd1:    r[23:16] = val;
        2'd2:    r[15:8]  = val;
        default: r[7:0]   = val;
      endcase
    end
    return r;
  endfunction

  assign accept  = bus.req_valid && (state == IDLE);
  assign bad_req = (bus.req_op > OP_SB) ||
                   (((bus.req_op == OP_LW) || (bus.req_op == OP_SW)) &&
                    (bus.req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bad_req)                  state_next = DONE;
          else if (bus.req_op == OP_SW) state_next = WR;
          else                          state_next = RD;
        end
      end
      RD:      if (bus.mem_ack) state_next = (op_q == OP_SB) ? WR : DONE;
      WR:      if (bus.mem_ack) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == DONE);
  end

  // Strobes are registered copies of the next state, so they track RD/WR exactly
  // and switch from read to write in a single edge during SB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.resp_data <= '0;
      bus.resp_rd   <= '0;
      bus.resp_err  <= 1'b0;
      op_q          <= '0;
      lane_q        <= '0;
      wbyte_q       <= '0;
    end else begin
      bus.mem_rd <= (state_next == RD);
      bus.mem_wr <= (state_next == WR);
      if (accept) begin
        bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        bus.resp_rd   <= bus.req_rd;
        bus.resp_err  <= bad_req;
        bus.resp_data <= '0;
        op_q          <= bus.req_op;
        lane_q        <= bus.req_addr[1:0];
        wbyte_q       <= bus.req_wdata[7:0];
        if (bus.req_op == OP_SW) bus.mem_wdata <= bus.req_wdata;
      end
      if ((state == RD) && bus.mem_ack) begin
        if (op_q == OP_SB)
          bus.mem_wdata <= byte_op(bus.mem_rdata, {2'b01, lane_q}, wbyte_q);
        else if (op_q == OP_LW)
          bus.resp_data <= bus.mem_rdata;
        else
          bus.resp_data <= byte_op(bus.mem_rdata, {(op_q == OP_LB), 1'b0, lane_q}, 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_byte_access.sv
// Directed bench for mem_byte_access with a programmable-latency memory responder.
module tb_mem_byte_access;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_byte_access_if #(.ADDR_W(32)) bus ();
  mem_byte_access #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model and responder
  logic [31:0] mem [logic [31:0]];
  int wait_rd = 0, wait_wr = 0, cnt = 0;
  int rd_cnt = 0, wr_cnt = 0, overlap = 0, unstable = 0;
  logic [31:0] rd_addr_log = '0, wr_addr_log = '0, wr_data_log = '0;
  logic p_rd = 1'b0, p_wr = 1'b0, p_ack = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_wr) overlap++;
      if (!(bus.mem_rd || bus.mem_wr)) begin
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
      end else begin
        if (p_ack || (p_rd != bus.mem_rd) || (p_wr != bus.mem_wr)) begin
          cnt = 0;
        end else begin
          cnt++;
          if ((bus.mem_addr != p_addr) || (bus.mem_wr && (bus.mem_wdata != p_wdata))) unstable++;
        end
        if (cnt >= (bus.mem_rd ? wait_rd : wait_wr)) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_rd) begin
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'd0;
            rd_cnt++;
            rd_addr_log = bus.mem_addr;
          end else begin
            mem[bus.mem_addr] = bus.mem_wdata;
            wr_cnt++;
            wr_addr_log = bus.mem_addr;
            wr_data_log = bus.mem_wdata;
          end
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 32'hDEADBEEF;
        end
      end
      p_rd    = bus.mem_rd;
      p_wr    = bus.mem_wr;
      p_ack   = bus.mem_ack;
      p_addr  = bus.mem_addr;
      p_wdata = bus.mem_wdata;
    end
  end

  logic [31:0] r_data;
  logic        r_err;
  logic [4:0]  r_rd;

  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        cyc    = i;
        r_data = bus.resp_data;
        r_err  = bus.resp_err;
        r_rd   = bus.resp_rd;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd, input int exp_cyc,
                     input logic [31:0] exp_data, input logic exp_err);
    int cyc;
    issue(op, addr, wdata, rd);
    wait_resp(cyc);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_data"}, r_data, exp_data);
    check({tag, "_err"}, {31'd0, r_err}, {31'd0, exp_err});
    check({tag, "_rd"}, {27'd0, r_rd}, {27'd0, rd});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  int rd0, wr0, seen;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;
    mem[32'h100] = 32'h12803456;
    mem[32'h200] = 32'hAABBCCDD;
    mem[32'h300] = 32'hAABBCCDD;

    #12;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd0 = rd_cnt; wr0 = wr_cnt;
    run("lb", 3'b001, 32'h101, 32'd0, 5'd5, 2, 32'hFFFFFF80, 1'b0);
    check("lb_nrd", rd_cnt - rd0, 1);
    check("lb_rdaddr", rd_addr_log, 32'h100);
    check("lb_nwr", wr_cnt - wr0, 0);
    run("lbu", 3'b010, 32'h101, 32'd0, 5'd6, 2, 32'h00000080, 1'b0);
    run("lw", 3'b000, 32'h100, 32'd0, 5'd7, 2, 32'h12803456, 1'b0);
    run("lb_lane3", 3'b001, 32'h103, 32'd0, 5'd8, 2, 32'h00000056, 1'b0);
    run("lbu_lane0", 3'b010, 32'h100, 32'd0, 5'd9, 2, 32'h00000012, 1'b0);

    run("sb", 3'b100, 32'h202, 32'hFFFFFF11, 5'd10, 3, 32'd0, 1'b0);
    check("sb_wraddr", wr_addr_log, 32'h200);
    check("sb_wrdata", wr_data_log, 32'hAABB11DD);

    wait_rd = 3; wait_wr = 3;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run("sb_wait", 3'b100, 32'h301, 32'h0000005A, 5'd11, 9, 32'd0, 1'b0);
    check("sb_wait_phases", {rd_cnt - rd0, wr_cnt - wr0}, {32'd1, 32'd1});
    check("sb_wait_stable", unstable, 0);
    check("sb_wait_overlap", overlap, 0);
    run("lw_wait", 3'b000, 32'h300, 32'd0, 5'd12, 5, 32'hAA5ACCDD, 1'b0);
    wait_rd = 0; wait_wr = 0;

    rd0 = rd_cnt; wr0 = wr_cnt;
    run("sw_misalign", 3'b011, 32'h102, 32'h12345678, 5'd13, 1, 32'd0, 1'b1);
    run("op_illegal", 3'b111, 32'h100, 32'd0, 5'd14, 1, 32'd0, 1'b1);
    run("lw_misalign", 3'b000, 32'h101, 32'd0, 5'd15, 1, 32'd0, 1'b1);
    check("err_nostrobe", {rd_cnt - rd0, wr_cnt - wr0}, 64'd0);
    run("sw", 3'b011, 32'h104, 32'hCAFEF00D, 5'd16, 2, 32'd0, 1'b0);
    check("sw_mem", mem[32'h104], 32'hCAFEF00D);

    // Reset while an SB sits in its write phase
    wait_wr = 20;
    wr0 = wr_cnt;
    issue(3'b100, 32'h200, 32'h00000077, 5'd17);
    repeat (3) @(negedge clk);
    check("rst_mid_inwr", {31'd0, bus.mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
    check("rst_mid_resp", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check("rst_mid_noresp", seen, 0);
    check("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mid_nowrite", wr_cnt - wr0, 0);
    wait_wr = 0;
    run("lw_after_rst", 3'b000, 32'h200, 32'd0, 5'd18, 2, 32'hAABB11DD, 1'b0);
    check("final_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_byte_access.md
# mem_byte_access

Memory-stage access controller for the 5-cycle MIPS core.
- Accepts one load/store per transaction from the EX/MEM boundary and drives a word-addressed, variable-latency data memory over a req/ack strobe interface.
- Performs byte extraction for LB/LBU and read-modify-write for SB using the existing byte_op block, and returns one response per transaction to the writeback path.

## Interface
Parameters:
- ADDR_W, 32, byte-address width (mem_addr has the same width).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_op  in  3  000 LW, 001 LB, 010 LBU, 011 SW, 100 SB; others illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; SB uses [7:0]
- req_rd  in  5  destination register tag, echoed on the response
- mem_addr  out  ADDR_W  word address, {req_addr[ADDR_W-1:2], 2'b00}, registered
- mem_rd  out  1  read strobe, registered, held until ack
- mem_wr  out  1  write strobe, registered, held until ack
- mem_wdata  out  32  write word, registered
- mem_rdata  in  32  read word, valid when mem_ack is high during a read
- mem_ack  in  1  completes the current strobe at the sampling edge
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  load result; 0 for stores and errors
- resp_rd  out  5  echoed req_rd
- resp_err  out  1  misaligned word access or illegal op

## Operation
- States: IDLE, RD, WR, DONE. req_ready = (state == IDLE).
- On accept, latch op, addr, wdata[7:0] or full wdata, and rd, then branch:
  - illegal op, or LW/SW with addr[1:0] != 0: go to DONE with err = 1. No memory strobe.
  - LW, LB, LBU, SB: go to RD; mem_rd = 1.
  - SW: go to WR; mem_wr = 1, mem_wdata = wdata.
- In RD, on mem_ack:
  - LW: capture rdata, go to DONE.
  - LB/LBU: capture byte_op(rdata, pos = {1 for LB else 0, 0, addr[1:0]}), go to DONE.
  - SB: drop mem_rd; mem_wdata = byte_op(rdata, pos = {2'b01, addr[1:0]}, val = wdata[7:0]); raise mem_wr; go to WR.
- In WR, on mem_ack: drop mem_wr, go to DONE.
- In DONE: resp_valid = 1 for exactly one cycle with data, rd, and err, then go to IDLE.
- Byte lane mapping (big-endian):
  - addr[1:0] = 00 selects bits [31:24]; 11 selects bits [7:0].
  - LB sign-extends from the selected byte's bit 7; LBU zero-extends.
- mem_rd and mem_wr are never high together. mem_addr stays stable for the whole transaction, across both SB phases.
- mem_ack is ignored in IDLE and DONE. A mem_rdata value without ack is never captured.

## Timing
- Reset (asynchronous, immediate): state = IDLE, mem_rd = mem_wr = 0, mem_addr = 0, mem_wdata = 0, resp_valid = 0, resp_data = 0, resp_rd = 0, resp_err = 0. req_ready = 1.
- Reset mid-transaction: strobes drop at once; no response is produced and no write is retried.
- Accept at edge 0. With zero-wait memory (ack high in the first strobe cycle):
  - LW/LB/LBU/SW: resp_valid in cycle 2.
  - SB: RD in cycle 1, WR in cycle 2, resp_valid in cycle 3.
  - Error path: resp_valid in cycle 1.
- Each memory wait cycle (ack low) adds one cycle. The strobe, address and wdata stay constant while waiting.
- Next accept is at the earliest in the cycle after the resp_valid cycle. Throughput is at most one transaction per 3 cycles.
- req_valid while not ready: ignored; the request must be held by upstream.

## Test plan
- LB: mem word 0x12_80_34_56, addr 0x101 → one mem_rd at 0x100; resp_data = 0xFFFFFF80, resp_valid at cycle 2.
- LBU: same word, addr 0x101 → resp_data = 0x00000080. LW at 0x100 → 0x12803456.
- SB: mem word 0xAABBCCDD, addr 0x202, wdata 0x11 → mem_rd, then mem_wr at 0x200 with wdata 0xAABB11DD; resp_err = 0, resp_valid at cycle 3.
- Wait states: ack delayed 3 cycles on both SB phases → strobe and address stable throughout; resp_valid at cycle 9; never rd and wr together.
- Error: SW at 0x102 → no strobe, resp_err = 1 at cycle 1. op = 111 behaves the same.
- Reset asserted in WR of an SB: mem_wr low immediately, no resp_valid; after release req_ready = 1 and a fresh LW completes normally.
